// File: rtl/bitorder_stream.sv
// bitorder_stream: regroups an LSB-first narrow beat stream into groups of
// WORD_BYTES bytes and re-emits each group with a selectable lane/byte order.
// Two ping-pong buffers give one beat per cycle of sustained throughput.
// Partial groups at frame end are discarded and flagged on drop.
module bitorder_stream #(
    parameter int DW         = 2,
    parameter int WORD_BYTES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          axiiv,
    input  logic [DW-1:0] axiid,
    output logic          axiov,
    output logic [DW-1:0] axiod,
    output logic          drop
);

    localparam int BPB   = 8 / DW;
    localparam int BEATS = BPB * WORD_BYTES;
    localparam int BW    = 8 * WORD_BYTES;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OW    = $clog2(BW);

    typedef enum logic [1:0] {
        B_IDLE,
        B_FILL,
        B_DRAIN
    } buf_state_t;

    typedef enum logic {
        FILL_A,
        FILL_B
    } sel_t;

    sel_t                   sel_q, sel_d;
    buf_state_t             bst_q [2];
    buf_state_t             bst_d [2];
    logic [1:0][BW-1:0]     buf_q;
    logic [IW-1:0]          i_q, j_q;
    logic [1:0]             frame_mode_q, grp_mode_q;
    logic                   in_frame_q;
    logic                   axiov_q, drop_q;
    logic [DW-1:0]          axiod_q;

    logic                   fs, ds;
    logic                   first_beat, last_in, swap;
    logic                   draining, drain_last;
    logic [1:0]             eff_mode;
    logic [OW-1:0]          wr_off, rd_off;
    logic [DW-1:0]          drain_beat;

    // Fill/drain control: which buffer does what, and when a group completes.
    always_comb begin
        fs         = (sel_q == FILL_B);
        ds         = ~fs;
        first_beat = axiiv && !in_frame_q;
        // The first beat of a frame already carries the new frame's mode.
        eff_mode   = first_beat ? mode : frame_mode_q;
        last_in    = (i_q == IW'(BEATS - 1));
        swap       = axiiv && last_in;
        draining   = (bst_q[ds] == B_DRAIN);
        drain_last = draining && (j_q == IW'(BEATS - 1));
        wr_off     = OW'(int'(i_q) * DW);
    end

    // Source slot of the current drain beat under the group's latched mode.
    always_comb begin
        int unsigned jb, jl, rb, rl;
        jb         = int'(j_q) / BPB;
        jl         = int'(j_q) % BPB;
        rb         = grp_mode_q[1] ? (WORD_BYTES - 1 - jb) : jb;
        rl         = grp_mode_q[0] ? (BPB - 1 - jl) : jl;
        rd_off     = OW'((rb * BPB + rl) * DW);
        drain_beat = buf_q[ds][rd_off +: DW];
    end

    // Buffer state machines and fill selector: next-state logic.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves a latch.
        sel_d = sel_q;
        bst_d = bst_q;
        if (drain_last) begin
            bst_d[ds] = B_IDLE;
        end
        // A swap may coincide with the old drain's last beat; the new roles win.
        if (swap) begin
            bst_d[fs] = B_DRAIN;
            bst_d[ds] = B_FILL;
            sel_d     = (sel_q == FILL_A) ? FILL_B : FILL_A;
        end
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffers are tiny and must read as zero after reset, so
            // unlike a RAM they are cleared with the rest of the state.
            sel_q        <= FILL_A;
            bst_q[0]     <= B_FILL;
            bst_q[1]     <= B_IDLE;
            buf_q        <= '0;
            i_q          <= '0;
            j_q          <= '0;
            frame_mode_q <= 2'b00;
            grp_mode_q   <= 2'b00;
            in_frame_q   <= 1'b0;
            axiov_q      <= 1'b0;
            axiod_q      <= '0;
            drop_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every read sees the
            // pre-edge value regardless of statement order.
            sel_q      <= sel_d;
            bst_q      <= bst_d;
            in_frame_q <= axiiv;
            drop_q     <= !axiiv && (i_q != '0);

            if (first_beat) begin
                frame_mode_q <= mode;
            end

            if (axiiv) begin
                buf_q[fs][wr_off +: DW] <= axiid;
                i_q <= last_in ? '0 : i_q + IW'(1);
            end else if (i_q != '0) begin
                // Frame ended mid-group: throw the partial group away.
                buf_q[fs] <= '0;
                i_q       <= '0;
            end

            if (swap) begin
                grp_mode_q <= eff_mode;
                j_q        <= '0;
            end else if (draining) begin
                j_q <= drain_last ? '0 : j_q + IW'(1);
            end

            axiov_q <= draining;
            axiod_q <= draining ? drain_beat : '0;
        end
    end

    // A fill completes no sooner than the previous drain, so a swap can only
    // land on an idle drain side or on the drain's final beat.
    always_ff @(posedge clk) begin
        if (!rst && swap) begin
            assert (!draining || drain_last);
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;
    assign drop  = drop_q;

endmodule

// File: doc/bitorder_stream.md
# bitorder_stream

Parametrised lane reorderer for the Ethernet receive path. It takes a narrow beat stream, carrying LSB-first lanes from the PHY (RMII dibits by default), and regroups it into groups of WORD_BYTES bytes. Each group is re-emitted with a run-time selectable lane and/or byte order. Ping-pong buffering gives one beat per cycle sustained throughput, and partial groups at frame end are dropped and flagged. It sits between the PHY receive front end and the frame checker / CRC block.

## Interface
- DW, default 2: bits per beat; must be 1, 2, 4 or 8.
- WORD_BYTES, default 1: bytes per reorder group; 1 to 4.
- Derived, not overridable:
  - BPB = 8/DW (beats per byte).
  - BEATS = BPB*WORD_BYTES (beats per group).
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- mode  input  2  bit0 = reverse lane order within each byte; bit1 = reverse byte order within group.
- axiiv  input  1  input beat valid; a contiguous high run is one frame.
- axiid  input  DW  input beat.
- axiov  output  1  output beat valid.
- axiod  output  DW  output beat.
- drop  output  1  one-cycle pulse: partial group discarded.

## Operation
- Two buffers of 8*WORD_BYTES bits. At any time one buffer is filling and at most one is draining.
- Fill: each cycle with axiiv=1, write axiid into the fill buffer at slot i (fill index, 0..BEATS-1), then increment i.
  - Slot i holds byte i/BPB, bits [DW*(i%BPB) +: DW].
- Group complete (i reaches BEATS-1 while axiiv=1):
  - Buffers swap roles in the same edge; i resets to 0.
  - Drain index j starts at 0.
  - The group's mode is latched with it.
- Drain: output beat j is the source slot with:
  - byte = mode[1] ? WORD_BYTES-1-j/BPB : j/BPB
  - lane = mode[0] ? BPB-1-j%BPB : j%BPB
- mode=01 with DW=2, WORD_BYTES=1 emits bits [7:6],[5:4],[3:2],[1:0]. This is the legacy MSB-first dibit order.
- mode is sampled on the first valid beat of a frame (axiiv rising after idle or reset) and held for every group in that frame. Changes mid-frame are ignored.
- Frame end: axiiv=0 with 0<i<BEATS:
  - Discard the fill contents and set i=0.
  - Pulse drop on the next cycle.
  - Any drain in progress continues unaffected.
- axiiv=0 with i=0 has no effect.
- A new frame may start the cycle after a frame ends, even while a drain is in progress.
  - Since a fill needs BEATS cycles and a drain needs BEATS cycles, a swap never collides with an active drain.
  - An implementation that asserts otherwise is in error.
- Beats after frame end are never merged into the previous frame's partial group.
- FSM per buffer has three states:
  - IDLE → FILL on being selected.
  - FILL → DRAIN on group complete.
  - DRAIN → IDLE after beat BEATS-1.
- Top-level selector: FILL_A or FILL_B.

## Timing
- Reset values:
  - axiov=0, axiod=0, drop=0.
  - i=j=0, both buffers zeroed, buffer A selected for fill, latched mode=00.
- Reset is taken mid-fill or mid-drain: outputs are 0 from the cycle after the reset edge, and all pending data is lost.
- Outputs are registered.
- Latency: if beat 0 of a group is accepted at edge c, output beat 0 is valid after edge c+BEATS, and beats continue contiguously for BEATS cycles.
- For a continuous frame of N*BEATS beats, axiov stays high for exactly N*BEATS contiguous cycles with no bubbles.
- axiov=0 ⇒ axiod=0; axiod never holds stale data.
- drop is high for exactly one cycle per discarded partial group.
- There is no back-pressure: the downstream block must accept one beat per cycle.

## Test plan
- DW=2, WORD_BYTES=1, mode=01: input 0xB4 as dibits 00,01,11,10.
  - Required: axiod 10,11,01,00 on four consecutive cycles, starting 4 cycles after the first input beat.
  - drop=0 throughout.
- DW=2, WORD_BYTES=2, each of the four modes: bytes 0x12,0x34 input LSB-first.
  - mode=00 reproduces the input beats.
  - mode=10 emits 0x34's dibits LSB-first, then 0x12's.
  - mode=11 emits 0x34 MSB-first, then 0x12 MSB-first.
- Back-to-back 64-byte frame, DW=2, mode=01, 1-cycle gap, then a second 64-byte frame.
  - Required: 256 contiguous valid beats per frame.
  - Data matches the MSB-first byte reference.
  - No drop pulses.
- Frame of 2 bytes + 1 dibit (DW=2, WORD_BYTES=1):
  - Required: 8 valid output beats.
  - drop pulses once, 1 cycle after axiiv falls.
  - The extra dibit never appears on the output.
- Mid-frame mode change from 01 to 00 at beat 5: every group in that frame is still emitted with mode 01. The next frame uses 00.
- rst asserted during the drain of the second beat:
  - Required: axiov=0 and axiod=0 from the next cycle.
  - A fresh frame after reset is reordered correctly with no residue from before reset.
